// File: rtl/cpu_cmp_sched.sv
// cpu_cmp_sched: one eq/slt/sltu comparator shared by NREQ requesters,
// with arbitration and a single registered response stage.
//
// Build option: define CPU_CMP_SCHED_RR_EN for round-robin arbitration.
// Leave it undefined for fixed priority (lowest index wins).
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous reset, active-high
//   req_valid_i     request valid, one bit per requester
//   req_ready_o     grant/accept, one-hot or zero, combinational
//   req_a_i         operand A, requester k at [32k+31:32k]
//   req_b_i         operand B, same packing
//   req_unsigned_i  1 = unsigned lt, 0 = signed lt
//   rsp_valid_o     response valid
//   rsp_ready_i     response consumer ready
//   rsp_id_o        requester index of the response
//   rsp_eq_o        A == B
//   rsp_lt_o        A < B, signed or unsigned per request
module cpu_cmp_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*32-1:0]   req_a_i,
  input  logic [NREQ*32-1:0]   req_b_i,
  input  logic [NREQ-1:0]      req_unsigned_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic                 rsp_eq_o,
  output logic                 rsp_lt_o
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic           eq_q, eq_d;
  logic           lt_q, lt_d;

  logic           can_accept;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic           xfer;

  logic [31:0]    a_sel;
  logic [31:0]    b_sel;
  logic           u_sel;
  logic           cmp_eq;
  logic           cmp_lt;

  // Reset blocks acceptance so nothing slips in while the stage clears.
  assign can_accept = !rst_i &&
    ((state_q == S_EMPTY) || rsp_ready_i);

`ifdef CPU_CMP_SCHED_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps at NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any &&
          req_valid_i[(int'(ptr_q) + i) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (gnt_idx == IDW'(NREQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scanning downward leaves the lowest index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt_oh = '0;
    for (int k = 0; k < NREQ; k++)
      gnt_oh[k] = gnt_any && (gnt_idx == IDW'(k));
  end

  assign req_ready_o = can_accept ? gnt_oh : '0;
  assign xfer        = can_accept && gnt_any;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    u_sel = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_oh[k]) begin
        a_sel = req_a_i[k*32 +: 32];
        b_sel = req_b_i[k*32 +: 32];
        u_sel = req_unsigned_i[k];
      end
    end
  end

  // Equal MSBs: the low 31 bits decide for both signednesses.
  // Differing MSBs: unsigned -> B bigger if B[31];
  // signed -> A negative if A[31].
  always_comb begin
    cmp_eq = (a_sel == b_sel);
    if (a_sel[31] == b_sel[31])
      cmp_lt = (a_sel[30:0] < b_sel[30:0]);
    else if (u_sel)
      cmp_lt = b_sel[31];
    else
      cmp_lt = a_sel[31];
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    if (xfer) begin
      state_d = S_FULL;
      id_d    = gnt_idx;
      eq_d    = cmp_eq;
      lt_d    = cmp_lt;
    end else if (rsp_ready_i) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      id_q    <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign rsp_valid_o = (state_q == S_FULL);
  assign rsp_id_o    = id_q;
  assign rsp_eq_o    = eq_q;
  assign rsp_lt_o    = lt_q;

endmodule
